mux_scan_sequencer: RTL
=======================

// Module: mux_scan_sequencer
// PURPOSE
//  Upstream sequencer for the 8:1 bit-select mux. Accepts a byte over a valid/ready
//  handshake, holds it on the mux data inputs and steps the 3-bit select 0..7 (or 7..0).
//  Each selected bit comes back from the mux and leaves on a valid/ready serial stream.
//  It turns the combinational selector into a flow-controlled parallel-to-serial stage.
// PARAMETERS
//  MSB_FIRST  0  0: select runs 0->7; 1: select runs 7->0
// PORTS
//  clk         in   1  rising-edge clock, single clock domain
//  rst_n       in   1  reset: asynchronous assert, active-low
//  in_valid    in   1  byte offered on in_data
//  in_ready    out  1  sequencer can accept a byte (high only in IDLE)
//  in_data     in   8  byte to serialise
//  mux_data    out  8  held byte, wired to mux data inputs
//  mux_addr    out  3  bit select, wired to mux address
//  mux_bit     in   1  mux output, = mux_data[mux_addr] combinationally
//  ser_valid   out  1  serial bit valid
//  ser_ready   in   1  downstream accepts ser_bit
//  ser_bit     out  1  current serial bit (= mux_bit while in SHIFT)
//  ser_last    out  1  final beat of the current byte
//  busy        out  1  high in SHIFT
// BEHAVIOUR
//  Reset values: in_ready=1, ser_valid=0, ser_last=0, busy=0, mux_data=8'h00.
//   mux_addr = 0 (MSB_FIRST=0) or 7 (MSB_FIRST=1).
//  FSM has two states, IDLE and SHIFT.
//   IDLE: in_ready=1. When in_valid&in_ready: latch in_data into mux_data,
//    load mux_addr with the start index, go to SHIFT.
//   SHIFT: ser_valid=1 and ser_bit=mux_bit. The stage never registers mux_bit.
//  Beat transfer is ser_valid&ser_ready.
//   On a transfer that is not the last beat, step mux_addr by +1 (or -1).
//   On the last-beat transfer, go to IDLE and restore mux_addr to the start index.
//  Beats per byte: 8, or 9 with PARITY_EN.
//   ser_last is high in the same cycle as the final beat.
//  Latency: first bit is valid 1 cycle after the accept cycle.
//   With ser_ready held at 1, a byte takes 8 cycles.
//   in_ready returns the cycle after the last beat, so there are no back-to-back bytes.
//   Peak throughput is 1 byte per 9 cycles (10 with parity).
//  While ser_ready=0, hold mux_addr, mux_data, ser_valid and ser_last stable.
//   ser_valid never drops without a transfer.
//  The select never wraps: the step from 7 (or 0) occurs only via last-beat exit.
//  in_valid while busy is ignored. in_ready=0, so nothing is lost.
//  rst_n low mid-byte aborts the byte immediately and asynchronously: all outputs take
//   their reset values and the partial byte is discarded. There is no resume.
//  mux_data changes only at the IDLE accept.
// CONFIGURATION
//  `MUX_SCAN_PARITY_EN defined: add a 9th beat after the data bits.
//   ser_bit = ^mux_data (even parity), mux_addr held at the final data index,
//   ser_last only on this beat. Parity is computed from the held byte, not mux_bit.
//  Not defined: 8 beats; the parity logic and beat-counter bit are absent.
// STRUCTURE
//  Shared package mux_scan_pkg:
//   typedef enum {IDLE, SHIFT} state_t
//   localparam ADDR_W = 3
//   localparam DATA_W = 8
//   localparam BEATS = DATA_W (+1 with parity)
//  One sub-module, mux_scan_ctrl: FSM, beat counter and address stepping.
//   The top holds the data register and handshake glue.
//  The mux itself stays outside and connects through the mux_* ports.
// TESTING
//  T1: reset, then in_data=8'hA5 with ser_ready=1, MSB_FIRST=0.
//   Expect bits 1,0,1,0,0,1,0,1 on consecutive cycles, ser_last on beat 8, mux_addr 0..7.
//  T2: MSB_FIRST=1, byte 8'h81.
//   Expect bits 1,0,0,0,0,0,0,1 with mux_addr 7..0, then mux_addr=7 in IDLE.
//  T3: 8'h3C with ser_ready toggled randomly.
//   Expect ser_bit, mux_addr and ser_valid stable while stalled, and the bit order intact.
//  T4: in_valid held high across two bytes 8'h01, 8'hFE.
//   Expect in_ready=0 during SHIFT, second accept 1 cycle after the first ser_last, no loss.
//  T5: rst_n pulsed low at beat 4 of 8'hFF.
//   Expect outputs at reset values the same cycle, in_ready=1, next byte serialises cleanly.
//  T6 (PARITY_EN): 8'h07.
//   Expect 9 beats, beat 9 ser_bit=1 with ser_last=1. For 8'h03 beat 9 = 0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux scan sequencer.
// Build option: define MUX_SCAN_PARITY_EN to append an even-parity beat to each byte.
package mux_scan_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;
`ifdef MUX_SCAN_PARITY_EN
    localparam int unsigned BEATS  = DATA_W + 1;
`else
    localparam int unsigned BEATS  = DATA_W;
`endif
    localparam int unsigned BEAT_W = $clog2(BEATS);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Sequencer control: IDLE/SHIFT FSM, beat counter and mux select stepping.
// Build option: MUX_SCAN_PARITY_EN adds the parity beat flag and a wider beat counter.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              ser_ready,
    output logic              in_ready,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy,
    output logic              load_c,
`ifdef MUX_SCAN_PARITY_EN
    output logic              par_beat,
`endif
    output logic [ADDR_W-1:0] mux_addr
);

    localparam logic [ADDR_W-1:0] START     = MSB_FIRST ? ADDR_W'(DATA_W - 1) : '0;
    localparam logic [BEAT_W-1:0] LAST_CNT  = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] PRE_LAST  = BEAT_W'(BEATS - 2);
    localparam logic [BEAT_W-1:0] LAST_DATA = BEAT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                last_q, last_d;
`ifdef MUX_SCAN_PARITY_EN
    logic                par_q, par_d;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= START;
            last_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
`ifdef MUX_SCAN_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next state: accept in IDLE, advance one beat per transfer in SHIFT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        last_d  = last_q;
`ifdef MUX_SCAN_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    addr_d  = START;
                    last_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        addr_d  = START;
                        last_d  = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
                        par_d   = 1'b0;
`endif
                    end else begin
                        cnt_d  = cnt_q + BEAT_W'(1);
                        last_d = (cnt_q == PRE_LAST);
                        // Select holds at the final data index during the parity beat
                        if (cnt_q < LAST_DATA) begin
                            addr_d = MSB_FIRST ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
                        end
`ifdef MUX_SCAN_PARITY_EN
                        par_d  = (cnt_q == LAST_DATA);
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_c    = (state_q == IDLE) && in_valid;
    assign in_ready  = (state_q == IDLE);
    assign ser_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign ser_last  = last_q;
    assign mux_addr  = addr_q;
`ifdef MUX_SCAN_PARITY_EN
    assign par_beat  = par_q;
`endif

endmodule

// File: rtl/mux_scan_sequencer.sv
// Flow-controlled parallel-to-serial stage driving an external 8:1 bit-select mux.
// Build option: MUX_SCAN_PARITY_EN sends even parity of the held byte as a 9th beat.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] mux_data,
    output logic [ADDR_W-1:0] mux_addr,
    input  logic              mux_bit,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_bit,
    output logic              ser_last,
    output logic              busy
);

    logic              load_c;
    logic [DATA_W-1:0] data_q;
`ifdef MUX_SCAN_PARITY_EN
    logic              par_beat;
`endif

    mux_scan_ctrl #(
        .MSB_FIRST (MSB_FIRST)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .ser_ready (ser_ready),
        .in_ready  (in_ready),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .busy      (busy),
        .load_c    (load_c),
`ifdef MUX_SCAN_PARITY_EN
        .par_beat  (par_beat),
`endif
        .mux_addr  (mux_addr)
    );

    // Byte held on the mux inputs; only an IDLE accept replaces it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_c) begin
            data_q <= in_data;
        end
    end

    assign mux_data = data_q;

    // The selected bit passes straight through; it is never registered here
`ifdef MUX_SCAN_PARITY_EN
    assign ser_bit = par_beat ? ^data_q : mux_bit;
`else
    assign ser_bit = mux_bit;
`endif

endmodule
